rs_syndrome: RTL and testbench



---
 rtl/rs_pkg.sv | 42 ++++
 rtl/gf_const_mult.sv | 14 +
 rtl/rs_syndrome.sv | 126 ++++++++++++
 tb/tb_rs_syndrome.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// RS(255,239) syndrome front end: shared field constants, state type
// and the constant-multiply helper used by every syndrome lane.
package rs_pkg;

    localparam int W     = 8;
    localparam int T     = 8;
    localparam int NSYN  = 2 * T;
    localparam int N_MAX = 255;

    localparam logic [W:0] FIELD_POLY = 9'h11D;

    localparam logic [W-1:0] ALPHA_POW [0:NSYN-1] = '{
        8'h01, 8'h02, 8'h04, 8'h08,
        8'h10, 8'h20, 8'h40, 8'h80,
        8'h1D, 8'h3A, 8'h74, 8'hE8,
        8'hCD, 8'h87, 8'h13, 8'h26
    };

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SHIFT
    } state_t;

    // shift-and-add multiply of a by constant k, reduced by FIELD_POLY
    function automatic logic [W-1:0] gf_mul_const(
        input logic [W-1:0] a,
        input logic [W-1:0] k
    );
        logic [W-1:0] acc;
        logic [W-1:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < W; i++) begin
            if (k[i]) acc = acc ^ x;
            if (x[W-1]) x = (x << 1) ^ FIELD_POLY[W-1:0];
            else        x = x << 1;
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf_const_mult.sv
// Combinational GF(2^8) multiply by the constant K, one per syndrome lane.
// Pure logic: the constant folds the function down to an XOR network.
module gf_const_mult
    import rs_pkg::*;
#(
    parameter logic [W-1:0] K = 8'h01
) (
    input  logic [W-1:0] i_a,
    output logic [W-1:0] o_p
);

    assign o_p = gf_mul_const(i_a, K);

endmodule

// File: rtl/rs_syndrome.sv
// Byte-serial syndrome evaluator S_j = r(alpha^j), j=0..2T-1, for RS(255,239).
// Optional RS_ERR_COUNT_EN adds a saturating err_count of failing codewords.
module rs_syndrome
    import rs_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_bits,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [W-1:0] syn_bits,
    output logic         syn_valid,
    output logic         syn_last,
    output logic         err_detected,
    output logic         len_err
`ifdef RS_ERR_COUNT_EN
    ,
    output logic [15:0]  err_count
`endif
);

    state_t       r_state;
    logic [W-1:0] r_syn [NSYN];
    logic [8:0]   r_count;
    logic [3:0]   r_k;
    logic         r_err;
    logic         r_len;

    logic [W-1:0] w_base [NSYN];
    logic [W-1:0] w_mul  [NSYN];
    logic [W-1:0] w_next [NSYN];
    logic         w_xfer;
    logic [8:0]   w_cnt1;
    logic         w_full;
    logic         w_end;
    logic         w_short;
    logic         w_last_k;
    logic         w_any;

    assign w_xfer   = in_valid & in_ready;
    assign w_cnt1   = r_count + 9'd1;
    assign w_full   = (w_cnt1 == 9'(N_MAX));
    assign w_end    = in_last | w_full;
    assign w_short  = (w_cnt1 < 9'(NSYN + 1));
    assign w_last_k = (r_k == 4'(NSYN - 1));

    // Horner step per lane; IDLE starts every lane from zero
    for (genvar j = 0; j < NSYN; j++) begin : g_lane
        assign w_base[j] = (r_state == IDLE) ? '0 : r_syn[j];
        gf_const_mult #(.K(ALPHA_POW[j])) u_mul (
            .i_a (w_base[j]),
            .o_p (w_mul[j])
        );
        assign w_next[j] = w_mul[j] ^ in_bits;
    end

    // any lane nonzero after the final symbol is folded in
    always_comb begin
        w_any = 1'b0;
        for (int j = 0; j < NSYN; j++) begin
            w_any = w_any | (|w_next[j]);
        end
    end

    // accumulate, then shift S_0..S_15 out; shifting in zeros clears S
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_k     <= '0;
            r_err   <= 1'b0;
            r_len   <= 1'b0;
            for (int j = 0; j < NSYN; j++) r_syn[j] <= '0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_xfer) begin
                        for (int j = 0; j < NSYN; j++) r_syn[j] <= w_next[j];
                        if (w_end) begin
                            r_state <= SHIFT;
                            r_count <= '0;
                            r_k     <= '0;
                            r_err   <= w_any;
                            r_len   <= w_short | (w_full & ~in_last);
                        end else begin
                            r_state <= ACCUM;
                            r_count <= w_cnt1;
                        end
                    end
                end
                SHIFT: begin
                    for (int j = 0; j < NSYN - 1; j++) r_syn[j] <= r_syn[j+1];
                    r_syn[NSYN-1] <= '0;
                    r_k <= r_k + 4'd1;
                    if (w_last_k) begin
                        r_state <= IDLE;
                        r_k     <= '0;
                        r_err   <= 1'b0;
                        r_len   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state != SHIFT);
    assign syn_valid    = (r_state == SHIFT);
    assign syn_bits     = syn_valid ? r_syn[0] : '0;
    assign syn_last     = syn_valid & w_last_k;
    assign err_detected = syn_valid & r_err;
    assign len_err      = syn_valid & r_len;

`ifdef RS_ERR_COUNT_EN
    // count codewords that left with a nonzero syndrome, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (syn_last && r_err && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rs_syndrome.sv
// Directed bench for rs_syndrome: known-answer syndromes, lengths, resets.
// Codewords come from a generator-polynomial LFSR encoder built here.
module tb_rs_syndrome;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_bits;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] syn_bits;
    logic       syn_valid;
    logic       syn_last;
    logic       err_detected;
    logic       len_err;
`ifdef RS_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    int errs   = 0;
    int checks = 0;

    logic [7:0] sym     [0:299];
    logic [7:0] exp_syn [0:15];
    logic [7:0] gpoly   [0:16];
    logic [7:0] ap      [0:15] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
        8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26
    };

    rs_syndrome dut (
        .clk          (clk),
        .reset        (reset),
        .in_bits      (in_bits),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .syn_bits     (syn_bits),
        .syn_valid    (syn_valid),
        .syn_last     (syn_last),
        .err_detected (err_detected),
        .len_err      (len_err)
`ifdef RS_ERR_COUNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return r;
    endfunction

    task automatic model_syn(input int n);
        logic [7:0] s;
        for (int j = 0; j < 16; j++) begin
            s = 8'h00;
            for (int i = 0; i < n; i++) s = gf_mul(s, ap[j]) ^ sym[i];
            exp_syn[j] = s;
        end
    endtask

    task automatic build_gen();
        for (int i = 0; i <= 16; i++) gpoly[i] = 8'h00;
        gpoly[0] = 8'h01;
        for (int j = 0; j < 16; j++) begin
            for (int i = 16; i >= 1; i--) gpoly[i] = gpoly[i-1] ^ gf_mul(gpoly[i], ap[j]);
            gpoly[0] = gf_mul(gpoly[0], ap[j]);
        end
    endtask

    // systematic encode: sym[0..n-17] data, parity written to sym[n-16..n-1]
    task automatic encode(input int n);
        logic [7:0] p [0:15];
        logic [7:0] fb;
        for (int k = 0; k < 16; k++) p[k] = 8'h00;
        for (int i = 0; i < n - 16; i++) begin
            fb = sym[i] ^ p[15];
            for (int k = 15; k >= 1; k--) p[k] = p[k-1] ^ gf_mul(fb, gpoly[k]);
            p[0] = gf_mul(fb, gpoly[0]);
        end
        for (int k = 0; k < 16; k++) sym[n-16+k] = p[15-k];
    endtask

    task automatic clear_sym();
        for (int i = 0; i < 300; i++) sym[i] = 8'h00;
    endtask

    task automatic feed(input int start, input int n, input int last_idx);
        for (int i = start; i < n; i++) begin
            @(negedge clk);
            in_bits  = sym[i];
            in_valid = 1'b1;
            in_last  = (i == last_idx);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bits  = 8'h00;
    endtask

    // samples ncyc SHIFT cycles starting at the current negedge
    task automatic collect(input string nm, input int ncyc,
                           input logic e_err, input logic e_len);
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (syn_valid !== 1'b1) begin
                errs++;
                $display("FAIL %s valid k=%0d got=%b exp=1", nm, k, syn_valid);
            end
            checks++;
            if (syn_bits !== exp_syn[k]) begin
                errs++;
                $display("FAIL %s S%0d got=%h exp=%h", nm, k, syn_bits, exp_syn[k]);
            end
            checks++;
            if (err_detected !== e_err) begin
                errs++;
                $display("FAIL %s err k=%0d got=%b exp=%b", nm, k, err_detected, e_err);
            end
            checks++;
            if (len_err !== e_len) begin
                errs++;
                $display("FAIL %s len k=%0d got=%b exp=%b", nm, k, len_err, e_len);
            end
            checks++;
            if (syn_last !== (k == 15)) begin
                errs++;
                $display("FAIL %s last k=%0d got=%b exp=%b", nm, k, syn_last, (k == 15));
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errs++;
                $display("FAIL %s ready k=%0d got=%b exp=0", nm, k, in_ready);
            end
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        checks++;
        if ({in_ready, syn_valid, syn_last, err_detected, len_err, syn_bits}
            !== {1'b1, 4'b0000, 8'h00}) begin
            errs++;
            $display("FAIL %s outputs got=%b%b%b%b%b_%h exp=10000_00", nm,
                     in_ready, syn_valid, syn_last, err_detected, len_err, syn_bits);
        end
    endtask

    task automatic quiet_window(input string nm, input int ncyc);
        int seen;
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (syn_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errs++;
            $display("FAIL %s stray syn_valid got=%0d exp=0", nm, seen);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bits  = 8'h00;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zeros();
        clear_sym();
        for (int j = 0; j < 16; j++) exp_syn[j] = 8'h00;
        feed(0, 255, 254);
        collect("zeros", 16, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (syn_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL zeros_after got=%b%b exp=01", syn_valid, in_ready);
        end
    endtask

    task automatic test_single_one();
        clear_sym();
        sym[254] = 8'h01;
        for (int j = 0; j < 16; j++) exp_syn[j] = 8'h01;
        feed(0, 255, 254);
        collect("one", 16, 1'b1, 1'b0);
    endtask

    task automatic test_alpha();
        clear_sym();
        sym[253] = 8'h01;
        for (int j = 0; j < 16; j++) exp_syn[j] = ap[j];
        feed(0, 255, 254);
        collect("alpha", 16, 1'b1, 1'b0);
    endtask

    task automatic test_encoder();
        clear_sym();
        for (int i = 0; i < 239; i++) sym[i] = 8'((i * 37 + 11) & 255);
        encode(255);
        for (int j = 0; j < 16; j++) exp_syn[j] = 8'h00;
        feed(0, 255, 254);
        collect("enc255", 16, 1'b0, 1'b0);
        sym[254] = sym[254] ^ 8'h5A;
        for (int j = 0; j < 16; j++) exp_syn[j] = 8'h5A;
        feed(0, 255, 254);
        collect("enc_flip", 16, 1'b1, 1'b0);
        clear_sym();
        for (int i = 0; i < 84; i++) sym[i] = 8'((i * 91 + 5) & 255);
        encode(100);
        for (int j = 0; j < 16; j++) exp_syn[j] = 8'h00;
        feed(0, 100, 99);
        collect("enc100", 16, 1'b0, 1'b0);
    endtask

    task automatic test_lengths();
        clear_sym();
        for (int i = 0; i < 10; i++) sym[i] = 8'(i + 1);
        model_syn(10);
        feed(0, 10, 9);
        collect("len10", 16, 1'b1, 1'b1);
        clear_sym();
        sym[0] = 8'hA5;
        for (int j = 0; j < 16; j++) exp_syn[j] = 8'hA5;
        feed(0, 1, 0);
        collect("len1", 16, 1'b1, 1'b1);
        clear_sym();
        sym[15] = 8'h03;
        for (int j = 0; j < 16; j++) exp_syn[j] = 8'h03;
        feed(0, 16, 15);
        collect("len16", 16, 1'b1, 1'b1);
        clear_sym();
        sym[16] = 8'h03;
        feed(0, 17, 16);
        collect("len17", 16, 1'b1, 1'b0);
    endtask

    task automatic test_forced_end();
        logic any;
        clear_sym();
        for (int i = 0; i < 255; i++) sym[i] = 8'(i) ^ 8'h3C;
        model_syn(255);
        any = 1'b0;
        for (int j = 0; j < 16; j++) any = any | (|exp_syn[j]);
        feed(0, 255, -1);
        in_valid = 1'b1;
        in_bits  = 8'h77;
        collect("forced", 16, any, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL forced_ready got=%b exp=1", in_ready);
        end
        clear_sym();
        sym[0] = 8'h77;
        model_syn(45);
        feed(1, 45, 44);
        collect("forced_next", 16, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        clear_sym();
        for (int i = 0; i < 50; i++) sym[i] = 8'(i * 7 + 1);
        feed(0, 50, -1);
        #2 reset = 1'b0;
        #1 check_idle_outputs("rst_accum");
        @(negedge clk);
        reset = 1'b1;
        quiet_window("rst_accum", 20);
        clear_sym();
        sym[254] = 8'h01;
        for (int j = 0; j < 16; j++) exp_syn[j] = 8'h01;
        feed(0, 255, 254);
        collect("after_rst_accum", 16, 1'b1, 1'b0);
        feed(0, 255, 254);
        collect("pre_rst_shift", 5, 1'b1, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_idle_outputs("rst_shift");
        @(negedge clk);
        reset = 1'b1;
        quiet_window("rst_shift", 20);
        clear_sym();
        sym[253] = 8'h01;
        for (int j = 0; j < 16; j++) exp_syn[j] = ap[j];
        feed(0, 255, 254);
        collect("after_rst_shift", 16, 1'b1, 1'b0);
    endtask

`ifdef RS_ERR_COUNT_EN
    task automatic test_err_count();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (err_count !== 16'd0) begin
            errs++;
            $display("FAIL errcnt_reset got=%0d exp=0", err_count);
        end
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            clear_sym();
            sym[16] = 8'(c + 5);
            for (int j = 0; j < 16; j++) exp_syn[j] = 8'(c + 5);
            feed(0, 17, 16);
            collect("errcnt_bad", 16, 1'b1, 1'b0);
        end
        clear_sym();
        for (int j = 0; j < 16; j++) exp_syn[j] = 8'h00;
        feed(0, 17, 16);
        collect("errcnt_good", 16, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (err_count !== 16'd3) begin
            errs++;
            $display("FAIL errcnt got=%0d exp=3", err_count);
        end
    endtask
`endif

    initial begin
        build_gen();
        test_reset();
        test_zeros();
        test_single_one();
        test_alpha();
        test_encoder();
        test_lengths();
        test_forced_end();
        test_reset_mid();
`ifdef RS_ERR_COUNT_EN
        test_err_count();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
